// File: rtl/rf_wb_scoreboard_pkg.sv
// Shared constants and types for the register-file writeback scoreboard.
// Imported by the top module and its load skid buffer.
package rf_wb_scoreboard_pkg;

    localparam int XLEN            = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int NUM_REGS        = 32;
    localparam int MAX_OUTSTANDING = 2;
    localparam int CNT_W           = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_BUF,
        WB_LOAD
    } wb_src_e;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry skid buffer for load returns that lose the write port to the ALU.
// Accepts only when empty; drains whenever the ALU leaves the port idle.
module wb_skid_buf
    import rf_wb_scoreboard_pkg::*;
#(
    parameter int DW = XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  reg_addr_t     i_rd,
    input  logic [DW-1:0] i_data,
    input  logic          i_port_busy,
    output logic          o_ready,
    output logic          o_valid,
    output reg_addr_t     o_rd,
    output logic [DW-1:0] o_data,
    output logic          o_drain
);

    logic          r_valid;
    reg_addr_t     r_rd;
    logic [DW-1:0] r_data;
    logic          w_capture;

    assign o_ready   = !r_valid;
    assign w_capture = i_valid && !r_valid && i_port_busy;
    assign o_drain   = r_valid && !i_port_busy;
    assign o_valid   = r_valid;
    assign o_rd      = r_rd;
    assign o_data    = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_rd    <= i_rd;
            r_data  <= i_data;
        end else if (o_drain) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register-file write-port arbiter (ALU > buffered load > direct load) and
// load scoreboard that stalls issue on RAW/WAW hazards or a full load budget.
module rf_wb_scoreboard #(
    parameter int XLEN            = rf_wb_scoreboard_pkg::XLEN,
    parameter int MAX_OUTSTANDING = rf_wb_scoreboard_pkg::MAX_OUTSTANDING,
    parameter int CNT_W           = rf_wb_scoreboard_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic            issue_rs1_used,
    input  logic            issue_rs2_used,
    input  logic [4:0]      issue_rd,
    input  logic            issue_wen,
    input  logic            issue_is_load,
    output logic            issue_stall,
    input  logic            alu_wen,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_wdata,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_wdata,
    output logic            ld_ready,
    output logic            rf_wen,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    import rf_wb_scoreboard_pkg::*;

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_cnt;

    logic            w_buf_valid;
    reg_addr_t       w_buf_rd;
    logic [XLEN-1:0] w_buf_data;
    logic            w_buf_drain;
    logic            w_ld_acc;
    logic            w_ld_direct;
    logic            w_retire;
    reg_addr_t       w_retire_rd;
    logic            w_load_issue;
    logic            w_raw;
    logic            w_waw;
    logic            w_full;
    wb_src_e         w_src;

    wb_skid_buf #(
        .DW (XLEN)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (ld_valid),
        .i_rd        (ld_rd),
        .i_data      (ld_wdata),
        .i_port_busy (alu_wen),
        .o_ready     (ld_ready),
        .o_valid     (w_buf_valid),
        .o_rd        (w_buf_rd),
        .o_data      (w_buf_data),
        .o_drain     (w_buf_drain)
    );

    assign w_ld_acc    = ld_valid && ld_ready;
    assign w_ld_direct = w_ld_acc && !alu_wen;
    assign w_retire    = w_buf_drain || w_ld_direct;
    assign w_retire_rd = w_buf_valid ? w_buf_rd : ld_rd;

    // Hazard checks see only registered state; a same-cycle retire releases next cycle.
    assign w_raw = (issue_rs1_used && r_pending[issue_rs1])
                || (issue_rs2_used && r_pending[issue_rs2]);
    assign w_waw  = issue_wen && r_pending[issue_rd];
    assign w_full = issue_is_load && (r_cnt == CNT_W'(MAX_OUTSTANDING));

    assign issue_stall  = issue_valid && (w_raw || w_waw || w_full);
    assign w_load_issue = issue_valid && !issue_stall && issue_is_load;

    always_comb begin
        w_src = WB_NONE;
        if (alu_wen)
            w_src = WB_ALU;
        else if (w_buf_valid)
            w_src = WB_BUF;
        else if (w_ld_acc)
            w_src = WB_LOAD;
    end

    always_comb begin
        rf_wen   = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        unique case (w_src)
            WB_ALU: begin
                rf_wen   = (alu_rd != '0);
                rf_rd    = alu_rd;
                rf_wdata = alu_wdata;
            end
            WB_BUF: begin
                rf_wen   = (w_buf_rd != '0);
                rf_rd    = w_buf_rd;
                rf_wdata = w_buf_data;
            end
            WB_LOAD: begin
                rf_wen   = (ld_rd != '0);
                rf_rd    = ld_rd;
                rf_wdata = ld_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            logic [NUM_REGS-1:0] v_next;
            v_next = r_pending;
            if (w_retire)
                v_next[w_retire_rd] = 1'b0;
            if (w_load_issue)
                v_next[issue_rd] = 1'b1;
            v_next[0] = 1'b0;
            r_pending <= v_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_load_issue && !w_retire) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_retire && !w_load_issue && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A retire with no load outstanding means the memory side broke protocol.
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(w_retire && !w_load_issue && r_cnt == '0)
    );

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Randomized and directed bench for rf_wb_scoreboard against a queue-based
// model of the scoreboard, load budget and write-port arbitration.
module tb_rf_wb_scoreboard;

    localparam int MAXO = 2;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_rs1_used;
    logic        issue_rs2_used;
    logic [4:0]  issue_rd;
    logic        issue_wen;
    logic        issue_is_load;
    logic        issue_stall;
    logic        alu_wen;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wdata;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_wdata;
    logic        ld_ready;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    bit [31:0]   m_pend;
    int          m_cnt;
    logic [4:0]  sk_rd[$];
    logic [31:0] sk_dat[$];
    logic [4:0]  mq[$];
    bit          m_acc;
    bit          m_li;

    rf_wb_scoreboard u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_wen      (issue_wen),
        .issue_is_load  (issue_is_load),
        .issue_stall    (issue_stall),
        .alu_wen        (alu_wen),
        .alu_rd         (alu_rd),
        .alu_wdata      (alu_wdata),
        .ld_valid       (ld_valid),
        .ld_rd          (ld_rd),
        .ld_wdata       (ld_wdata),
        .ld_ready       (ld_ready),
        .rf_wen         (rf_wen),
        .rf_rd          (rf_rd),
        .rf_wdata       (rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid    = 0;
        issue_rs1      = 0;
        issue_rs2      = 0;
        issue_rs1_used = 0;
        issue_rs2_used = 0;
        issue_rd       = 0;
        issue_wen      = 0;
        issue_is_load  = 0;
        alu_wen        = 0;
        alu_rd         = 0;
        alu_wdata      = 0;
        ld_valid       = 0;
        ld_rd          = 0;
        ld_wdata       = 0;
    endtask

    task automatic iss(input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2,
                       input logic [4:0] rd, input bit wen, input bit ld);
        issue_valid    = 1;
        issue_rs1      = rs1;
        issue_rs1_used = u1;
        issue_rs2      = rs2;
        issue_rs2_used = u2;
        issue_rd       = rd;
        issue_wen      = wen;
        issue_is_load  = ld;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_wen   = 1;
        alu_rd    = rd;
        alu_wdata = d;
    endtask

    task automatic ldr(input logic [4:0] rd, input logic [31:0] d);
        ld_valid = 1;
        ld_rd    = rd;
        ld_wdata = d;
    endtask

    task automatic model_clear();
        m_pend = 0;
        m_cnt  = 0;
        sk_rd.delete();
        sk_dat.delete();
        mq.delete();
        m_acc = 0;
        m_li  = 0;
    endtask

    task automatic retire(input logic [4:0] rd);
        m_pend[rd] = 1'b0;
        m_cnt--;
    endtask

    // Check the current cycle's outputs, then advance the model across the edge.
    task automatic step();
        bit          stall;
        bit          ew;
        logic [4:0]  er;
        logic [31:0] ed;
        #1;
        stall = issue_valid &&
                ((issue_rs1_used && m_pend[issue_rs1]) ||
                 (issue_rs2_used && m_pend[issue_rs2]) ||
                 (issue_wen && m_pend[issue_rd]) ||
                 (issue_is_load && m_cnt == MAXO));
        chk("issue_stall", {31'b0, issue_stall}, {31'b0, stall});
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, sk_rd.size() == 0});
        m_acc = ld_valid && sk_rd.size() == 0;
        ew = 0;
        er = 0;
        ed = 0;
        if (alu_wen) begin
            ew = alu_rd != 0; er = alu_rd; ed = alu_wdata;
        end else if (sk_rd.size() != 0) begin
            ew = sk_rd[0] != 0; er = sk_rd[0]; ed = sk_dat[0];
        end else if (m_acc) begin
            ew = ld_rd != 0; er = ld_rd; ed = ld_wdata;
        end
        chk("rf_wen", {31'b0, rf_wen}, {31'b0, ew});
        if (ew) begin
            chk("rf_rd", {27'b0, rf_rd}, {27'b0, er});
            chk("rf_wdata", rf_wdata, ed);
        end
        if (!alu_wen && sk_rd.size() != 0) begin
            retire(sk_rd.pop_front());
            void'(sk_dat.pop_front());
        end else if (m_acc && alu_wen) begin
            sk_rd.push_back(ld_rd);
            sk_dat.push_back(ld_wdata);
        end else if (m_acc) begin
            retire(ld_rd);
        end
        m_li = issue_valid && !stall && issue_is_load;
        if (m_li) begin
            if (issue_rd != 0) m_pend[issue_rd] = 1'b1;
            m_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_clear();
        @(negedge clk);

        // Load-use stall and release one cycle after retire
        do_reset();
        step();
        iss(0, 0, 0, 0, 5, 1, 1); step();
        idle(); iss(5, 1, 0, 0, 6, 1, 0); step();
        ldr(5, 32'hDEADBEEF); step();
        idle(); iss(5, 1, 0, 0, 6, 1, 0); step();

        // ALU wins the port; load goes through the skid buffer
        do_reset();
        iss(0, 0, 0, 0, 7, 1, 1); step();
        idle(); alu(3, 32'h11); ldr(7, 32'h22); step();
        idle(); step();
        step();

        // Load budget exhausted
        do_reset();
        iss(0, 0, 0, 0, 1, 1, 1); step();
        iss(0, 0, 0, 0, 2, 1, 1); step();
        iss(0, 0, 0, 0, 4, 1, 1); step();
        ldr(1, 32'hA1); step();
        ld_valid = 0; step();
        idle(); ldr(2, 32'hA2); step();
        ldr(4, 32'hA4); step();
        idle(); step();

        // Loads and ALU writes targeting x0
        do_reset();
        iss(0, 0, 0, 0, 0, 1, 1); step();
        idle(); ldr(0, 32'h55); step();
        idle(); alu(0, 32'h99); step();
        idle(); iss(0, 0, 0, 0, 1, 1, 1); step();
        idle(); step();

        // WAW stall, then overlapping load issue and retire
        do_reset();
        iss(0, 0, 0, 0, 9, 1, 1); step();
        idle(); iss(1, 1, 2, 1, 9, 1, 0); step();
        ldr(9, 32'h99); step();
        idle(); iss(1, 1, 2, 1, 9, 1, 0); step();
        idle(); iss(0, 0, 0, 0, 10, 1, 1); step();
        idle(); iss(0, 0, 0, 0, 11, 1, 1); ldr(10, 32'h10); step();
        idle(); iss(0, 0, 0, 0, 12, 1, 1); step();
        idle(); ldr(11, 32'h11); step();
        ldr(12, 32'h12); step();
        idle(); step();

        // Reset while the buffer is full and the budget is used up
        do_reset();
        iss(0, 0, 0, 0, 1, 1, 1); step();
        iss(0, 0, 0, 0, 2, 1, 1); step();
        idle(); alu(3, 32'h33); ldr(1, 32'h44); step();
        idle();
        rst_n = 0;
        iss(2, 1, 0, 0, 1, 1, 1);
        #1;
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("rst_stall", {31'b0, issue_stall}, 32'd0);
        chk("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
        idle();
        model_clear();
        @(negedge clk);
        rst_n = 1;
        iss(2, 1, 1, 1, 1, 1, 1); step();
        idle(); step();

        // Randomized traffic with an in-order memory model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit keep;
            keep = ld_valid && !m_acc;
            issue_valid    = $urandom_range(0, 3) != 0;
            issue_rs1      = 5'($urandom_range(0, 7));
            issue_rs2      = 5'($urandom_range(0, 7));
            issue_rs1_used = 1'($urandom_range(0, 1));
            issue_rs2_used = 1'($urandom_range(0, 1));
            issue_rd       = 5'($urandom_range(0, 7));
            issue_is_load  = $urandom_range(0, 2) == 0;
            issue_wen      = issue_is_load ? 1'b1 : 1'($urandom_range(0, 1));
            alu_rd         = 5'($urandom_range(0, 7));
            alu_wdata      = $urandom;
            alu_wen        = ($urandom_range(0, 2) == 0) && !m_pend[alu_rd];
            if (!keep) begin
                if (mq.size() != 0 && $urandom_range(0, 1) == 1) begin
                    ld_valid = 1;
                    ld_rd    = mq[0];
                    ld_wdata = $urandom;
                end else begin
                    ld_valid = 0;
                end
            end
            step();
            if (m_acc) void'(mq.pop_front());
            if (m_li) mq.push_back(issue_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
